kypd_scan_reader: RTL and testbench

Scanned-matrix input reader for a 4x4 Pmod keypad, the input-side counterpart of the display's multiplexed digit drive. Drives one column low at a time, samples the four rows, debounces over whole scan frames, and emits a hex key code with a one-cycle press strobe. Sits between the keypad Pmod pins and the digit/entry logic that feeds the seven-segment display.

---
 rtl/kypd_pkg.sv | 65 ++++++
 rtl/kypd_col_scan.sv | 69 ++++++
 rtl/kypd_scan_reader.sv | 235 +++++++++++++++++++++++
 tb/tb_kypd_scan_reader.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/kypd_pkg.sv
// -----------------------------------------------------------------------------
// kypd_pkg
// Shared types and constants for the 4x4 keypad scan reader:
//   - frame_res_e  : per-frame scan result (NONE / KEY / MULTI)
//   - kypd_state_e : debounce FSM state (IDLE / PRESSED)
//   - KEY_MAP      : 16-nibble key map indexed by {col,row}
//   - COL_RESET    : column drive pattern after reset (column 0 low)
// Helper functions: key_lookup, count_low, first_low.
// -----------------------------------------------------------------------------
package kypd_pkg;

    typedef enum logic [1:0] {
        RES_NONE  = 2'd0,
        RES_KEY   = 2'd1,
        RES_MULTI = 2'd2
    } frame_res_e;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_PRESSED = 1'b1
    } kypd_state_e;

    localparam logic [3:0] COL_RESET = 4'b1110;

    // Nibble n holds the key at {col,row} = n; nibble 0 is column 0 / row 0.
    localparam logic [63:0] KEY_MAP = {
        4'hD, 4'hC, 4'hB, 4'hA,   // column 3, rows 3..0
        4'hE, 4'h9, 4'h6, 4'h3,   // column 2
        4'hF, 4'h8, 4'h5, 4'h2,   // column 1
        4'h0, 4'h7, 4'h4, 4'h1    // column 0
    };

    function automatic logic [3:0] key_lookup(input logic [1:0] c, input logic [1:0] r);
        return KEY_MAP[{c, r, 2'b00} +: 4];
    endfunction

    // Number of active-low rows asserted in one column sample.
    function automatic logic [2:0] count_low(input logic [3:0] rows);
        logic [2:0] n;
        n = 3'd0;
        for (int i = 0; i < 4; i++) begin
            if (!rows[i]) begin
                n = n + 3'd1;
            end else begin
                n = n;
            end
        end
        return n;
    endfunction

    // Index of the lowest-numbered asserted row (only meaningful when one is low).
    function automatic logic [1:0] first_low(input logic [3:0] rows);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!rows[i]) begin
                idx = 2'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/kypd_col_scan.sv
// -----------------------------------------------------------------------------
// kypd_col_scan
// Column scan timebase: prescaler over SCAN_DIV cycles per column slot and a
// 2-bit column counter driving a one-hot active-low column pattern.
// Ports:
//   clk, rst_n         clock, async active-low reset
//   col_o[3:0]         registered column drive (~(1<<index))
//   col_idx_o[1:0]     current column index
//   sample_strobe_o    last cycle of a column slot (sample rows now)
//   frame_end_o        last cycle of the column-3 slot
// -----------------------------------------------------------------------------
module kypd_col_scan
    import kypd_pkg::*;
#(
    parameter int SCAN_DIV = 100000
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic [3:0] col_o,
    output logic [1:0] col_idx_o,
    output logic       sample_strobe_o,
    output logic       frame_end_o
);

    localparam int PW = $clog2(SCAN_DIV);
    localparam logic [PW-1:0] PRESC_MAX = PW'(SCAN_DIV - 1);

    if (SCAN_DIV < 4) begin : g_bad_div
        $error("SCAN_DIV must be at least 4");
    end

    logic [PW-1:0] presc_q, presc_d;
    logic [1:0]    idx_q, idx_d;
    logic [3:0]    col_q, col_d;
    logic          slot_end_s;

    // Prescaler wrap and column advance; col_d is decoded from the next index so
    // the drive pattern changes in the same cycle the index does.
    always_comb begin
        slot_end_s = (presc_q == PRESC_MAX);
        if (slot_end_s) begin
            presc_d = '0;
            idx_d   = idx_q + 2'd1;
        end else begin
            presc_d = presc_q + PW'(1);
            idx_d   = idx_q;
        end
        col_d = ~(4'b0001 << idx_d);
    end

    // Scan counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
            idx_q   <= 2'd0;
            col_q   <= COL_RESET;
        end else begin
            presc_q <= presc_d;
            idx_q   <= idx_d;
            col_q   <= col_d;
        end
    end

    assign col_o           = col_q;
    assign col_idx_o       = idx_q;
    assign sample_strobe_o = slot_end_s;
    assign frame_end_o     = slot_end_s && (idx_q == 2'd3);

endmodule

// File: rtl/kypd_scan_reader.sv
// -----------------------------------------------------------------------------
// kypd_scan_reader
// 4x4 Pmod keypad reader: scans columns, samples synchronized rows, classifies
// each 4-slot frame as NONE/KEY/MULTI and debounces over whole frames.
// Ports:
//   clk, rst_n      clock, async active-low reset
//   row[3:0]        keypad rows, active-low
//   col[3:0]        column drive, one-hot active-low
//   key_code[3:0]   hex code of the accepted key (held after release)
//   key_valid       one-cycle pulse on an accepted press
//   key_down        an accepted key is currently held
// Optional: define KYPD_REPEAT_EN for auto-repeat every REPEAT_FRAMES frames.
// -----------------------------------------------------------------------------
module kypd_scan_reader
    import kypd_pkg::*;
#(
    parameter int SCAN_DIV        = 100000,
    parameter int DEBOUNCE_FRAMES = 4,
    parameter int REPEAT_FRAMES   = 50
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_down
);

    localparam int CW = $clog2(DEBOUNCE_FRAMES + 1);
    localparam logic [CW-1:0] DEB_MAX = CW'(DEBOUNCE_FRAMES);

    if (DEBOUNCE_FRAMES < 1) begin : g_bad_deb
        $error("DEBOUNCE_FRAMES must be at least 1");
    end
    if (REPEAT_FRAMES < 1) begin : g_bad_rep
        $error("REPEAT_FRAMES must be at least 1");
    end

    logic [1:0] col_idx_s;
    logic       sample_s;
    logic       frame_end_s;

    kypd_col_scan #(.SCAN_DIV(SCAN_DIV)) u_col_scan (
        .clk             (clk),
        .rst_n           (rst_n),
        .col_o           (col),
        .col_idx_o       (col_idx_s),
        .sample_strobe_o (sample_s),
        .frame_end_o     (frame_end_s)
    );

    // Two-flop row synchronizer; resets to "no key" (all high).
    logic [3:0] row_s1_q, row_s2_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_s1_q <= 4'hF;
            row_s2_q <= 4'hF;
        end else begin
            row_s1_q <= row;
            row_s2_q <= row_s1_q;
        end
    end

    // Frame accumulator: saturating switch count (0,1,2+) and the code of the
    // first closed switch seen in the frame.
    logic [1:0]  acc_cnt_q, acc_cnt_d;
    logic [3:0]  acc_code_q, acc_code_d;
    logic [2:0]  slot_lows_s;
    logic [2:0]  total_s;
    logic [1:0]  total_sat_s;
    logic [3:0]  frame_code_s;
    frame_res_e  frame_res_s;

    // Fold the current column sample into the frame tally and classify at frame end.
    always_comb begin
        slot_lows_s  = count_low(row_s2_q);
        total_s      = {1'b0, acc_cnt_q} + slot_lows_s;
        total_sat_s  = (total_s >= 3'd2) ? 2'd2 : total_s[1:0];
        frame_code_s = (acc_cnt_q == 2'd0) ? key_lookup(col_idx_s, first_low(row_s2_q))
                                           : acc_code_q;
        case (total_sat_s)
            2'd0:    frame_res_s = RES_NONE;
            2'd1:    frame_res_s = RES_KEY;
            default: frame_res_s = RES_MULTI;
        endcase
        if (sample_s) begin
            acc_cnt_d  = frame_end_s ? 2'd0 : total_sat_s;
            acc_code_d = frame_end_s ? 4'h0 : frame_code_s;
        end else begin
            acc_cnt_d  = acc_cnt_q;
            acc_code_d = acc_code_q;
        end
    end

    // Frame accumulator registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_cnt_q  <= 2'd0;
            acc_code_q <= 4'h0;
        end else begin
            acc_cnt_q  <= acc_cnt_d;
            acc_code_q <= acc_code_d;
        end
    end

    kypd_state_e state_q, state_d;
    logic [3:0]  cand_q, cand_d;
    logic        cand_vld_q, cand_vld_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc_s;
    logic [3:0]  key_code_q, key_code_d;
    logic        key_valid_q, key_valid_d;
    logic        key_down_q, key_down_d;
    logic        held_match_s;

`ifdef KYPD_REPEAT_EN
    localparam int RW = $clog2(REPEAT_FRAMES + 1);
    localparam logic [RW-1:0] REP_MAX = RW'(REPEAT_FRAMES);
    logic [RW-1:0] rep_q, rep_d;
`endif

    // Debounce FSM, stepped once per frame end. cnt_q is the press count in
    // IDLE and the release count in PRESSED.
    always_comb begin
        state_d      = state_q;
        cand_d       = cand_q;
        cand_vld_d   = cand_vld_q;
        cnt_d        = cnt_q;
        key_code_d   = key_code_q;
        key_valid_d  = 1'b0;
        key_down_d   = key_down_q;
`ifdef KYPD_REPEAT_EN
        rep_d        = rep_q;
`endif
        held_match_s = (frame_res_s == RES_KEY) && (frame_code_s == key_code_q);
        if (state_q == ST_IDLE && cand_vld_q && frame_code_s == cand_q) begin
            cnt_inc_s = cnt_q + CW'(1);
        end else if (state_q == ST_IDLE) begin
            cnt_inc_s = CW'(1);
        end else begin
            cnt_inc_s = cnt_q + CW'(1);
        end

        if (frame_end_s) begin
            case (state_q)
                ST_IDLE: begin
                    if (frame_res_s == RES_KEY) begin
                        if (cnt_inc_s == DEB_MAX) begin
                            state_d     = ST_PRESSED;
                            key_code_d  = frame_code_s;
                            key_valid_d = 1'b1;
                            key_down_d  = 1'b1;
                            cnt_d       = '0;
                            cand_d      = 4'h0;
                            cand_vld_d  = 1'b0;
`ifdef KYPD_REPEAT_EN
                            rep_d       = '0;
`endif
                        end else begin
                            cnt_d      = cnt_inc_s;
                            cand_d     = frame_code_s;
                            cand_vld_d = 1'b1;
                        end
                    end else begin
                        cnt_d      = '0;
                        cand_d     = 4'h0;
                        cand_vld_d = 1'b0;
                    end
                end
                ST_PRESSED: begin
                    if (held_match_s) begin
                        cnt_d = '0;
`ifdef KYPD_REPEAT_EN
                        if (rep_q + RW'(1) == REP_MAX) begin
                            key_valid_d = 1'b1;
                            rep_d       = '0;
                        end else begin
                            rep_d = rep_q + RW'(1);
                        end
`endif
                    end else if (cnt_inc_s == DEB_MAX) begin
                        state_d    = ST_IDLE;
                        key_down_d = 1'b0;
                        cnt_d      = '0;
`ifdef KYPD_REPEAT_EN
                        rep_d      = '0;
`endif
                    end else begin
                        cnt_d = cnt_inc_s;
                    end
                end
                default: begin
                    state_d    = ST_IDLE;
                    cnt_d      = '0;
                    cand_vld_d = 1'b0;
                    key_down_d = 1'b0;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // FSM and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cand_q      <= 4'h0;
            cand_vld_q  <= 1'b0;
            cnt_q       <= '0;
            key_code_q  <= 4'h0;
            key_valid_q <= 1'b0;
            key_down_q  <= 1'b0;
`ifdef KYPD_REPEAT_EN
            rep_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cand_q      <= cand_d;
            cand_vld_q  <= cand_vld_d;
            cnt_q       <= cnt_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            key_down_q  <= key_down_d;
`ifdef KYPD_REPEAT_EN
            rep_q       <= rep_d;
`endif
        end
    end

    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;
    assign key_down  = key_down_q;

endmodule

// File: tb/tb_kypd_scan_reader.sv
// -----------------------------------------------------------------------------
// tb_kypd_scan_reader
// Frame-aligned keypad stimulus (directed scenarios then random frames). A
// behavioural model classifies each frame by counting pressed switches and
// applies the press/release/repeat rules; expected strobes (code + time) go to
// a queue that a separate monitor pops whenever key_valid is seen.
// -----------------------------------------------------------------------------
module tb_kypd_scan_reader;

    localparam int SCAN_DIV = 4;
    localparam int DEB      = 2;
    localparam int REP      = 3;
    localparam int FRAME    = 4 * SCAN_DIV;
    localparam time PERIOD  = 10;

    logic       clk;
    logic       rst_n;
    logic [3:0] row;
    logic [3:0] col;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_down;

    kypd_scan_reader #(
        .SCAN_DIV        (SCAN_DIV),
        .DEBOUNCE_FRAMES (DEB),
        .REPEAT_FRAMES   (REP)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .row       (row),
        .col       (col),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_down  (key_down)
    );

    initial clk = 1'b0;
    always #(PERIOD / 2) clk = ~clk;

    // Physical keypad: bit c*4+r closed pulls row r low while column c is driven low.
    logic [15:0] pressed;
    always_comb begin
        row = 4'hF;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                if (!col[c] && pressed[c * 4 + r]) row[r] = 1'b0;
            end
        end
    end

    // Key printed at position c*4+r.
    int key_at [16] = '{1, 4, 7, 0, 2, 5, 8, 15, 3, 6, 9, 14, 10, 11, 12, 13};

    typedef struct {
        logic [3:0] code;
        time        t;
    } exp_t;
    exp_t exp_q[$];

    int checks = 0;
    int errors = 0;

    // Reference model state.
    bit         m_held;
    bit         m_cand_ok;
    int         m_cand;
    int         m_run;
    int         m_rel;
    int         m_rep;
    logic [3:0] m_code_out;

    function automatic int pos_of(input int code);
        for (int i = 0; i < 16; i++) if (key_at[i] == code) return i;
        return 0;
    endfunction

    task automatic model_reset();
        m_held = 0; m_cand_ok = 0; m_cand = 0; m_run = 0;
        m_rel = 0; m_rep = 0; m_code_out = 4'h0;
    endtask

    task automatic push_exp(input logic [3:0] code, input time t);
        exp_t e;
        e.code = code;
        e.t    = t;
        exp_q.push_back(e);
    endtask

    // Apply one frame's worth of switch state to the model.
    task automatic model_frame(input logic [15:0] mask, input time t_end);
        int  n;
        int  code;
        bit  is_key;
        n      = $countones(mask);
        is_key = (n == 1);
        code   = -1;
        for (int i = 0; i < 16; i++) if (is_key && mask[i]) code = key_at[i];
        if (!m_held) begin
            if (is_key) begin
                m_run     = (m_cand_ok && code == m_cand) ? m_run + 1 : 1;
                m_cand    = code;
                m_cand_ok = 1;
                if (m_run == DEB) begin
                    m_held     = 1;
                    m_code_out = 4'(code);
                    m_run = 0; m_rel = 0; m_rep = 0; m_cand_ok = 0;
                    push_exp(4'(code), t_end);
                end
            end else begin
                m_run = 0; m_cand_ok = 0;
            end
        end else begin
            if (is_key && code == int'(m_code_out)) begin
                m_rel = 0;
`ifdef KYPD_REPEAT_EN
                m_rep++;
                if (m_rep == REP) begin
                    m_rep = 0;
                    push_exp(m_code_out, t_end);
                end
`endif
            end else begin
                m_rel++;
                if (m_rel == DEB) begin
                    m_held = 0; m_rel = 0; m_rep = 0;
                end
            end
        end
    endtask

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    // One full frame starting at a slot-0 negedge; checks column walk and levels.
    task automatic run_frame(input logic [15:0] mask);
        logic [3:0] exp_col;
        pressed = mask;
        model_frame(mask, $time + FRAME * PERIOD);
        for (int j = 0; j < FRAME; j++) begin
            exp_col = ~(4'b0001 << (j / SCAN_DIV));
            check("col", col, exp_col);
            @(negedge clk);
        end
        check("key_down", {3'b000, key_down}, {3'b000, m_held});
        check("key_code", key_code, m_code_out);
    endtask

    task automatic frames(input logic [15:0] mask, input int n);
        for (int i = 0; i < n; i++) run_frame(mask);
    endtask

    function automatic logic [15:0] key_mask(input int code);
        logic [15:0] m;
        m = 16'h0000;
        m[pos_of(code)] = 1'b1;
        return m;
    endfunction

    task automatic check_reset_vals(input string tag);
        check({tag, "_col"},   col, 4'b1110);
        check({tag, "_code"},  key_code, 4'h0);
        check({tag, "_valid"}, {3'b000, key_valid}, 4'h0);
        check({tag, "_down"},  {3'b000, key_down}, 4'h0);
    endtask

    // Monitor: every strobe must match the head of the expectation queue.
    always @(negedge clk) begin
        if (rst_n && key_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL strobe: unexpected key_valid code %h at %0t", key_code, $time);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (key_code !== e.code || $time != e.t) begin
                    errors++;
                    $display("FAIL strobe: got code %h at %0t expected code %h at %0t",
                             key_code, $time, e.code, e.t);
                end
            end
        end
    end

    initial begin
        logic [15:0] cur;
        int          sel;
        int          a;
        int          b;
        rst_n   = 1'b0;
        pressed = 16'h0000;
        model_reset();
        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        rst_n = 1'b1;

        // Idle scanning.
        frames(16'h0000, 2);
        // Steady key 5, then release.
        frames(key_mask(5), 4);
        frames(16'h0000, 3);
        // Key 9 bouncing: one frame on, one off, then held.
        frames(key_mask(9), 1);
        frames(16'h0000, 1);
        frames(key_mask(9), 3);
        frames(16'h0000, 3);
        // Keys 1 and D together, then only D.
        frames(key_mask(1) | key_mask(13), 3);
        frames(key_mask(13), 3);
        frames(16'h0000, 3);
        // Key A held, reset pulsed mid-frame.
        frames(key_mask(10), 3);
        pressed = key_mask(10);
        repeat (7) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_vals("midrst");
        model_reset();
        repeat (2) @(negedge clk);
        check_reset_vals("inrst");
        rst_n = 1'b1;
        frames(key_mask(10), 3);
        frames(16'h0000, 3);
        // Key 0 held long (auto-repeat when enabled).
        frames(key_mask(0), 12);
        frames(16'h0000, 3);

        // Random frames.
        cur = 16'h0000;
        for (int f = 0; f < 80; f++) begin
            sel = int'($urandom_range(0, 9));
            if (sel >= 4 && sel <= 5) begin
                cur = 16'h0000;
            end else if (sel >= 6 && sel <= 8) begin
                cur = 16'h0000;
                cur[$urandom_range(0, 15)] = 1'b1;
            end else if (sel == 9) begin
                a = int'($urandom_range(0, 15));
                b = (a + int'($urandom_range(1, 15))) % 16;
                cur = 16'h0000;
                cur[a] = 1'b1;
                cur[b] = 1'b1;
            end
            run_frame(cur);
        end
        frames(16'h0000, 3);
        repeat (5) @(negedge clk);

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL missing_strobe: %0d expected strobes never seen", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
